// File: rtl/fp16_vec_accum_if.sv
// ============================================================================
// fp16_vec_accum_if : operand stream in, reduction result out (valid/ready)
// Rev 1.0
// ============================================================================
`default_nettype none

interface fp16_vec_accum_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_inf;
    logic             out_cnt_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_inf, out_cnt_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_inf, out_cnt_sat
    );
endinterface

`default_nettype wire

// File: rtl/fp16_vec_accum.sv
// ============================================================================
// fp16_vec_accum : streaming FP16 vector reduction (running sum, count, flags)
// Rev 1.0
// ============================================================================
`default_nettype none

module float_adder (
    input  wire logic [15:0] i_a,
    input  wire logic [15:0] i_b,
    output logic      [15:0] o_sum
);
    logic        w_a_big;
    logic [15:0] w_big;
    logic [15:0] w_sml;
    logic [5:0]  w_eb;
    logic [5:0]  w_es;
    logic [10:0] w_mb;
    logic [10:0] w_ms;
    logic [5:0]  w_diff;
    logic [13:0] w_align;
    logic [14:0] w_sum;
    logic [3:0]  w_lz;
    logic [5:0]  w_shift;
    logic [13:0] w_norm;
    logic [6:0]  w_exp;

    always_comb begin
        // Magnitude order falls out of an unsigned compare of exponent|mantissa.
        w_a_big = (i_a[14:0] >= i_b[14:0]);
        w_big   = w_a_big ? i_a : i_b;
        w_sml   = w_a_big ? i_b : i_a;
        w_eb    = {1'b0, (w_big[14:10] == 5'd0) ? 5'd1 : w_big[14:10]};
        w_es    = {1'b0, (w_sml[14:10] == 5'd0) ? 5'd1 : w_sml[14:10]};
        w_mb    = {|w_big[14:10], w_big[9:0]};
        w_ms    = {|w_sml[14:10], w_sml[9:0]};
        w_diff  = w_eb - w_es;
        w_align = (w_diff > 6'd13) ? 14'd0 : ({w_ms, 3'b000} >> w_diff);

        if (w_big[15] ^ w_sml[15])
            w_sum = {1'b0, w_mb, 3'b000} - {1'b0, w_align};
        else
            w_sum = {1'b0, w_mb, 3'b000} + {1'b0, w_align};

        w_lz = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (w_sum[i])
                w_lz = 4'(13 - i);
        end

        w_shift = 6'd0;
        w_norm  = 14'd0;
        w_exp   = 7'd0;
        if (w_sum[14]) begin
            w_norm = w_sum[14:1];
            w_exp  = {1'b0, w_eb} + 7'd1;
        end else begin
            // Left-normalise, but never below exponent 1 (denormal range).
            w_shift = ({2'b00, w_lz} > (w_eb - 6'd1)) ? (w_eb - 6'd1) : {2'b00, w_lz};
            w_norm  = w_sum[13:0] << w_shift;
            w_exp   = {1'b0, w_eb - w_shift};
            if (!w_norm[13])
                w_exp = 7'd0;
        end

        if (w_sum == 15'd0)
            o_sum = 16'h0000;
        else if (w_exp >= 7'd31)
            o_sum = {w_big[15], 5'h1F, 10'h000};
        else
            o_sum = {w_big[15], w_exp[4:0], w_norm[12:3]};
    end
endmodule

module fp16_vec_accum #(
    parameter int CNT_W = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fp16_vec_accum_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_acc;
    logic [15:0]      w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_inf;
    logic             w_inf_nxt;
    logic             r_sat;
    logic             w_sat_nxt;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_start;
    logic [15:0]      w_add_sum;

    float_adder u_add (
        .i_a   (r_acc),
        .i_b   (bus.in_data),
        .o_sum (w_add_sum)
    );

    assign w_in_ready = (r_state != ST_HOLD) | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    // A beat accepted while the result drains opens the next vector directly.
    assign w_start    = w_accept & (r_state != ST_ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= 16'h0000;
            r_cnt   <= '0;
            r_inf   <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_inf   <= w_inf_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_inf_nxt   = r_inf;
        w_sat_nxt   = r_sat;

        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_start) begin
                    w_acc_nxt   = bus.in_data;
                    w_cnt_nxt   = CNT_W'(1);
                    w_inf_nxt   = (bus.in_data[14:10] == 5'h1F);
                    w_sat_nxt   = 1'b0;
                    w_state_nxt = bus.in_last ? ST_HOLD : ST_ACC;
                end else if (r_state == ST_HOLD && bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (w_accept) begin
                    if (!r_inf) begin
                        w_acc_nxt = w_add_sum;
                        w_inf_nxt = (w_add_sum[14:10] == 5'h1F);
                    end
                    if (&r_cnt)
                        w_sat_nxt = 1'b1;
                    else
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (bus.in_last)
                        w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == ST_HOLD);
    assign bus.out_data    = r_acc;
    assign bus.out_count   = r_cnt;
    assign bus.out_inf     = r_inf;
    assign bus.out_cnt_sat = r_sat;
endmodule

`default_nettype wire

// File: tb/tb_fp16_vec_accum.sv
// ============================================================================
// tb_fp16_vec_accum : directed vectors for the FP16 vector accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp16_vec_accum;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fp16_vec_accum_if #(.CNT_W(8)) u_if ();
    fp16_vec_accum_if #(.CNT_W(2)) u_if2 ();

    fp16_vec_accum #(.CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    fp16_vec_accum #(.CNT_W(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [15:0] d, input logic l);
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        u_if.in_last  = l;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
    endtask

    task automatic beat2(input logic [15:0] d, input logic l);
        u_if2.in_valid = 1'b1;
        u_if2.in_data  = d;
        u_if2.in_last  = l;
        @(posedge clk); #1;
        u_if2.in_valid = 1'b0;
        u_if2.in_last  = 1'b0;
    endtask

    task automatic drain();
        u_if.out_ready = 1'b1;
        @(posedge clk); #1;
        u_if.out_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        u_if.in_valid  = 1'b0; u_if.in_data  = 16'h0; u_if.in_last  = 1'b0; u_if.out_ready  = 1'b0;
        u_if2.in_valid = 1'b0; u_if2.in_data = 16'h0; u_if2.in_last = 1'b0; u_if2.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst_out_data",  32'(u_if.out_data),  32'h0);
        chk("rst_out_count", 32'(u_if.out_count), 32'd0);
        chk("rst_in_ready",  32'(u_if.in_ready),  32'd1);
        chk("rst_flags",     32'({u_if.out_inf, u_if.out_cnt_sat}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1.0 + 2.0 + 0.5
        beat(16'h3C00, 1'b0);
        beat(16'h4000, 1'b0);
        chk("t1_not_yet_valid", 32'(u_if.out_valid), 32'd0);
        beat(16'h3800, 1'b1);
        chk("t1_valid",  32'(u_if.out_valid), 32'd1);
        chk("t1_data",   32'(u_if.out_data),  32'h4300);
        chk("t1_count",  32'(u_if.out_count), 32'd3);
        chk("t1_flags",  32'({u_if.out_inf, u_if.out_cnt_sat}), 32'd0);
        drain();
        chk("t1_drained", 32'(u_if.out_valid), 32'd0);

        // 1.0 + -1.0
        beat(16'h3C00, 1'b0);
        beat(16'hBC00, 1'b1);
        chk("t2_data",  32'(u_if.out_data),  32'h0000);
        chk("t2_count", 32'(u_if.out_count), 32'd2);
        chk("t2_inf",   32'(u_if.out_inf),   32'd0);
        drain();

        // overflow to inf, sticky across the third beat
        beat(16'h7BFF, 1'b0);
        beat(16'h7BFF, 1'b0);
        beat(16'h3C00, 1'b1);
        chk("t3_data",  32'(u_if.out_data),  32'h7C00);
        chk("t3_inf",   32'(u_if.out_inf),   32'd1);
        chk("t3_count", 32'(u_if.out_count), 32'd3);
        drain();

        // single beat held under back-pressure, then back-to-back next vector
        beat(16'hC200, 1'b1);
        u_if.in_valid = 1'b1;
        u_if.in_data  = 16'h4000;
        u_if.in_last  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_hold_valid", 32'(u_if.out_valid), 32'd1);
        chk("t4_hold_data",  32'(u_if.out_data),  32'hC200);
        chk("t4_hold_count", 32'(u_if.out_count), 32'd1);
        chk("t4_in_ready",   32'(u_if.in_ready),  32'd0);
        u_if.out_ready = 1'b1;
        @(posedge clk); #1;
        u_if.out_ready = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_last   = 1'b0;
        chk("t4_b2b_valid", 32'(u_if.out_valid), 32'd1);
        chk("t4_b2b_data",  32'(u_if.out_data),  32'h4000);
        chk("t4_b2b_count", 32'(u_if.out_count), 32'd1);
        drain();
        chk("t4_drained", 32'(u_if.out_valid), 32'd0);

        // bubbles inside a vector
        beat(16'h3C00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("bub_open", 32'(u_if.out_valid), 32'd0);
        beat(16'h3C00, 1'b1);
        chk("bub_data",  32'(u_if.out_data),  32'h4000);
        chk("bub_count", 32'(u_if.out_count), 32'd2);
        drain();

        // saturating 2-bit counter, six ones
        for (int i = 0; i < 6; i++)
            beat2(16'h3C00, (i == 5));
        chk("t5_valid", 32'(u_if2.out_valid),   32'd1);
        chk("t5_count", 32'(u_if2.out_count),   32'd3);
        chk("t5_sat",   32'(u_if2.out_cnt_sat), 32'd1);
        chk("t5_data",  32'(u_if2.out_data),    32'h4600);

        // reset mid-vector discards the partial sum
        beat(16'h3C00, 1'b0);
        beat(16'h3C00, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(u_if.out_valid), 32'd0);
        chk("t6_rst_ready", 32'(u_if.in_ready),  32'd1);
        chk("t6_rst_count", 32'(u_if.out_count), 32'd0);
        chk("t6_rst_sat2",  32'(u_if2.out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(16'h4000, 1'b1);
        chk("t6_data",  32'(u_if.out_data),  32'h4000);
        chk("t6_count", 32'(u_if.out_count), 32'd1);
        chk("t6_valid", 32'(u_if.out_valid), 32'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
